// File: rtl/match_tracker_pkg.sv
// Shared types and default constants for the match tracker.
package match_pkg;

  localparam int unsigned DEF_W       = 2;
  localparam int unsigned DEF_RUN_LEN = 3;
  localparam int unsigned DEF_CNT_W   = 8;
  // Run counter only ever reaches RUN_LEN-1 (max 14), so 4 bits suffice.
  localparam int unsigned RUN_W       = 4;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

endpackage

// File: rtl/match_tracker_if.sv
// Operand-pair input stream, result output stream and statistics.
interface match_tracker_if
  import match_pkg::*;
#(
  parameter int unsigned W     = DEF_W,
  parameter int unsigned CNT_W = DEF_CNT_W
);

  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     a;
  logic [W-1:0]     b;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_a;
  logic [W-1:0]     out_b;
  logic             out_eq;
  logic             run_hit;
  logic [CNT_W-1:0] match_cnt;
  logic [CNT_W-1:0] mismatch_cnt;

  // Upstream producer / downstream consumer side
  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, out_a, out_b, out_eq, run_hit,
           match_cnt, mismatch_cnt
  );

  // Tracker side
  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, out_a, out_b, out_eq, run_hit,
           match_cnt, mismatch_cnt
  );

endinterface

// File: rtl/match_tracker_pair_eq.sv
// Full-width operand equality compare.
module pair_eq
  import match_pkg::*;
#(
  parameter int unsigned W = DEF_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         eq
);

  assign eq = (a == b);

endmodule

// File: rtl/match_tracker.sv
// Compares operand pairs through a single-entry result register and keeps
// saturating match/mismatch counts plus a non-overlapping match-run detector.
module match_tracker
  import match_pkg::*;
#(
  parameter int unsigned W       = DEF_W,
  parameter int unsigned RUN_LEN = DEF_RUN_LEN,
  parameter int unsigned CNT_W   = DEF_CNT_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  match_tracker_if.slave  bus
);

  state_t           state_q;
  logic [W-1:0]     out_a_q;
  logic [W-1:0]     out_b_q;
  logic             out_eq_q;
  logic             run_hit_q;
  logic [CNT_W-1:0] match_q;
  logic [CNT_W-1:0] mismatch_q;
  logic [RUN_W-1:0] run_q;

  logic             eq_c;
  logic             accept_c;
  logic             consume_c;
  logic [CNT_W-1:0] match_base_c;
  logic [CNT_W-1:0] mismatch_base_c;
  logic [RUN_W-1:0] run_base_c;
  logic [RUN_W-1:0] run_inc_c;
  logic             run_done_c;

  pair_eq #(.W(W)) u_pair_eq (
    .a  (bus.a),
    .b  (bus.b),
    .eq (eq_c)
  );

  // Single-entry output register: ready whenever it is empty or draining.
  assign bus.in_ready = (state_q == EMPTY) || bus.out_ready;
  assign accept_c     = bus.in_valid && bus.in_ready;
  assign consume_c    = (state_q == FULL) && bus.out_ready;

  // Clear takes effect before the coincident pair is counted.
  assign match_base_c    = clear ? '0 : match_q;
  assign mismatch_base_c = clear ? '0 : mismatch_q;
  assign run_base_c      = clear ? '0 : run_q;
  assign run_inc_c       = run_base_c + RUN_W'(1);
  assign run_done_c      = (run_inc_c == RUN_W'(RUN_LEN));

  // Handshake FSM and held result; result only changes on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= EMPTY;
      out_a_q   <= '0;
      out_b_q   <= '0;
      out_eq_q  <= 1'b0;
      run_hit_q <= 1'b0;
    end else begin
      unique case (state_q)
        EMPTY:   if (accept_c) state_q <= FULL;
        FULL:    if (!accept_c && consume_c) state_q <= EMPTY;
        default: state_q <= EMPTY;
      endcase
      if (accept_c) begin
        out_a_q   <= bus.a;
        out_b_q   <= bus.b;
        out_eq_q  <= eq_c;
        run_hit_q <= eq_c && run_done_c;
      end
    end
  end

  // Saturating statistics and run counter, stepped once per accepted pair.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match_q    <= '0;
      mismatch_q <= '0;
      run_q      <= '0;
    end else begin
      match_q    <= match_base_c;
      mismatch_q <= mismatch_base_c;
      run_q      <= run_base_c;
      if (accept_c) begin
        if (eq_c) begin
          match_q <= (match_base_c == '1) ? match_base_c
                                          : match_base_c + CNT_W'(1);
          run_q   <= run_done_c ? '0 : run_inc_c;
        end else begin
          mismatch_q <= (mismatch_base_c == '1) ? mismatch_base_c
                                                : mismatch_base_c + CNT_W'(1);
          run_q      <= '0;
        end
      end
    end
  end

  assign bus.out_valid    = (state_q == FULL);
  assign bus.out_a        = out_a_q;
  assign bus.out_b        = out_b_q;
  assign bus.out_eq       = out_eq_q;
  assign bus.run_hit      = run_hit_q;
  assign bus.match_cnt    = match_q;
  assign bus.mismatch_cnt = mismatch_q;

endmodule

// File: tb/tb_match_tracker.sv
// Directed bench for match_tracker: a default instance plus a 2-bit counter
// instance fed the same stimulus to observe saturation.
module tb_match_tracker;

  logic clk;
  logic rst_n;
  logic clear;

  int checks;
  int fails;

  match_tracker_if #(.W(2), .CNT_W(8)) bus1 ();
  match_tracker_if #(.W(2), .CNT_W(2)) bus2 ();

  assign bus2.in_valid  = bus1.in_valid;
  assign bus2.a         = bus1.a;
  assign bus2.b         = bus1.b;
  assign bus2.out_ready = bus1.out_ready;

  match_tracker #(.W(2), .RUN_LEN(3), .CNT_W(8)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .bus   (bus1)
  );

  match_tracker #(.W(2), .RUN_LEN(3), .CNT_W(2)) u_dut_sat (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .bus   (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [1:0] pa, input logic [1:0] pb);
    bus1.a        = pa;
    bus1.b        = pb;
    bus1.in_valid = 1'b1;
  endtask

  logic [1:0] a_vec  [8];
  logic [1:0] b_vec  [8];
  logic       eq_vec [8];
  logic       hit_vec[6];
  logic [1:0] pa4    [4];
  logic [1:0] pb4    [4];
  logic       eq4    [4];

  initial begin
    checks = 0;
    fails  = 0;
    rst_n  = 1'b0;
    clear  = 1'b0;
    bus1.in_valid  = 1'b0;
    bus1.a         = '0;
    bus1.b         = '0;
    bus1.out_ready = 1'b1;

    // Reset state
    #1;
    chk("rst_out_valid", 32'(bus1.out_valid), 32'd0);
    chk("rst_in_ready", 32'(bus1.in_ready), 32'd1);
    chk("rst_match", 32'(bus1.match_cnt), 32'd0);
    chk("rst_mismatch", 32'(bus1.mismatch_cnt), 32'd0);
    chk("rst_out_a", 32'(bus1.out_a), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Basic compares, latency 1
    pa4 = '{2'd3, 2'd2, 2'd2, 2'd1};
    pb4 = '{2'd2, 2'd3, 2'd2, 2'd3};
    eq4 = '{1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      put(pa4[i], pb4[i]);
      step();
      chk("basic_valid", 32'(bus1.out_valid), 32'd1);
      chk("basic_eq", 32'(bus1.out_eq), 32'(eq4[i]));
      chk("basic_out_a", 32'(bus1.out_a), 32'(pa4[i]));
      chk("basic_out_b", 32'(bus1.out_b), 32'(pb4[i]));
    end
    chk("basic_match", 32'(bus1.match_cnt), 32'd1);
    chk("basic_mismatch", 32'(bus1.mismatch_cnt), 32'd3);
    bus1.in_valid = 1'b0;
    step();
    chk("drain_valid", 32'(bus1.out_valid), 32'd0);

    // Runs of (1,1): hits on 3rd and 6th, proving run counter restarts
    hit_vec = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 6; i++) begin
      put(2'd1, 2'd1);
      step();
      chk("run_hit", 32'(bus1.run_hit), 32'(hit_vec[i]));
      chk("run_eq", 32'(bus1.out_eq), 32'd1);
    end
    chk("run_match", 32'(bus1.match_cnt), 32'd7);
    chk("run_mismatch", 32'(bus1.mismatch_cnt), 32'd3);
    chk("sat_match", 32'(bus2.match_cnt), 32'd3);
    chk("sat_mismatch", 32'(bus2.mismatch_cnt), 32'd3);

    // Backpressure: held result, no accept
    put(2'd0, 2'd3);
    bus1.out_ready = 1'b0;
    #1;
    chk("bp_in_ready_c", 32'(bus1.in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_valid", 32'(bus1.out_valid), 32'd1);
      chk("bp_in_ready", 32'(bus1.in_ready), 32'd0);
      chk("bp_out_a", 32'(bus1.out_a), 32'd1);
      chk("bp_out_b", 32'(bus1.out_b), 32'd1);
      chk("bp_hit", 32'(bus1.run_hit), 32'd1);
      chk("bp_match", 32'(bus1.match_cnt), 32'd7);
      chk("bp_mismatch", 32'(bus1.mismatch_cnt), 32'd3);
    end
    bus1.out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(bus1.in_ready), 32'd1);
    step();
    chk("bp_new_a", 32'(bus1.out_a), 32'd0);
    chk("bp_new_b", 32'(bus1.out_b), 32'd3);
    chk("bp_new_eq", 32'(bus1.out_eq), 32'd0);
    chk("bp_new_hit", 32'(bus1.run_hit), 32'd0);
    chk("bp_new_mismatch", 32'(bus1.mismatch_cnt), 32'd4);

    // Clear alone keeps the held result
    bus1.in_valid  = 1'b0;
    bus1.out_ready = 1'b0;
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("clr_match", 32'(bus1.match_cnt), 32'd0);
    chk("clr_mismatch", 32'(bus1.mismatch_cnt), 32'd0);
    chk("clr_valid", 32'(bus1.out_valid), 32'd1);
    chk("clr_held_b", 32'(bus1.out_b), 32'd3);

    // Build counts 4/4 with alternating results
    a_vec  = '{2'd1, 2'd0, 2'd2, 2'd3, 2'd3, 2'd1, 2'd0, 2'd2};
    b_vec  = '{2'd1, 2'd1, 2'd2, 2'd0, 2'd3, 2'd2, 2'd0, 2'd1};
    eq_vec = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    bus1.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      put(a_vec[i], b_vec[i]);
      step();
      chk("alt_eq", 32'(bus1.out_eq), 32'(eq_vec[i]));
    end
    chk("alt_match", 32'(bus1.match_cnt), 32'd4);
    chk("alt_mismatch", 32'(bus1.mismatch_cnt), 32'd4);

    // Clear coincident with accepted (2,2)
    put(2'd2, 2'd2);
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("clracc_match", 32'(bus1.match_cnt), 32'd1);
    chk("clracc_mismatch", 32'(bus1.mismatch_cnt), 32'd0);
    chk("clracc_valid", 32'(bus1.out_valid), 32'd1);
    chk("clracc_eq", 32'(bus1.out_eq), 32'd1);
    chk("clracc_sat_match", 32'(bus2.match_cnt), 32'd1);
    // Run counter restarted at 1: third match in total raises run_hit
    put(2'd2, 2'd2);
    step();
    chk("clrrun_hit2", 32'(bus1.run_hit), 32'd0);
    step();
    chk("clrrun_hit3", 32'(bus1.run_hit), 32'd1);
    chk("clrrun_match", 32'(bus1.match_cnt), 32'd3);

    // Asynchronous reset while a result is held
    bus1.in_valid  = 1'b0;
    bus1.out_ready = 1'b0;
    step();
    chk("pre_rst_valid", 32'(bus1.out_valid), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(bus1.out_valid), 32'd0);
    chk("arst_out_a", 32'(bus1.out_a), 32'd0);
    chk("arst_out_b", 32'(bus1.out_b), 32'd0);
    chk("arst_eq", 32'(bus1.out_eq), 32'd0);
    chk("arst_hit", 32'(bus1.run_hit), 32'd0);
    chk("arst_match", 32'(bus1.match_cnt), 32'd0);
    chk("arst_in_ready", 32'(bus1.in_ready), 32'd1);
    chk("arst_sat_match", 32'(bus2.match_cnt), 32'd0);
    step();
    rst_n = 1'b1;
    chk("post_rst_valid", 32'(bus1.out_valid), 32'd0);

    // Normal operation resumes
    bus1.out_ready = 1'b1;
    put(2'd3, 2'd3);
    step();
    chk("resume_valid", 32'(bus1.out_valid), 32'd1);
    chk("resume_eq", 32'(bus1.out_eq), 32'd1);
    chk("resume_match", 32'(bus1.match_cnt), 32'd1);
    bus1.in_valid = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/match_tracker.md
MATCH_TRACKER -- requirements
Module: match_tracker

Interface
REQ-001 SHALL have parameter W, default 2, operand width in bits.
REQ-002 SHALL have parameter RUN_LEN, default 3, consecutive-match count that raises run_hit (legal range 1..15).
REQ-003 SHALL have parameter CNT_W, default 8, width of the statistics counters.
REQ-004 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port in_valid, input, 1, operand pair a/b presented.
REQ-007 SHALL have port in_ready, output, 1, block accepts a pair this cycle.
REQ-008 SHALL have ports a and b, input, W each, operands to compare.
REQ-009 SHALL have port clear, input, 1, synchronous clear of counters and run state.
REQ-010 SHALL have port out_valid, output, 1, result register holds an unconsumed result.
REQ-011 SHALL have port out_ready, input, 1, downstream consumes the result.
REQ-012 SHALL have ports out_a and out_b, output, W each, registered copy of the compared pair.
REQ-013 SHALL have port out_eq, output, 1, 1 when out_a equals out_b.
REQ-014 SHALL have port run_hit, output, 1, qualified by out_valid; this result completed a run of RUN_LEN matches.
REQ-015 SHALL have ports match_cnt and mismatch_cnt, output, CNT_W each, accepted equal / unequal pairs since reset or clear.

Function
REQ-016 SHALL accept a pair when in_valid and in_ready are both 1 (accept); out_valid and out_ready both 1 is a consume.
REQ-017 SHALL drive in_ready = !out_valid || out_ready (single-entry output register, combinational ready path).
REQ-018 SHALL present an accepted pair's result on out_* with out_valid=1 on the cycle after accept (latency 1).
REQ-019 SHALL hold out_a, out_b, out_eq, run_hit stable while out_valid=1 and out_ready=0.
REQ-020 SHALL use a two-state FSM: EMPTY (out_valid=0), FULL (out_valid=1).
REQ-021 EMPTY to FULL on accept; FULL to FULL on accept together with consume (back-to-back, one result per cycle); FULL to EMPTY on consume without accept.
REQ-022 SHALL compute out_eq as a full W-bit equality, not a per-bit or partial compare.
REQ-023 SHALL increment match_cnt or mismatch_cnt by exactly one per accept, on the accept edge.
REQ-024 Counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-025 SHALL keep a run counter: +1 on an accepted match, reset to 0 on an accepted mismatch.
REQ-026 When an accepted match brings the run counter to RUN_LEN, SHALL set run_hit=1 for that result and reset the run counter to 0 (non-overlapping runs).
REQ-027 clear SHALL zero both counters and the run counter, and SHALL NOT disturb out_valid or the held result.
REQ-028 clear coincident with accept SHALL apply clear first, then count the new pair (its counter reads 1, run counter 1 or 0 per REQ-026).
REQ-029 Without accept, counters and run counter SHALL hold; in_valid while in_ready=0 SHALL have no effect.

Reset
REQ-030 rst_n low SHALL immediately force FSM to EMPTY, out_valid=0, out_a=0, out_b=0, out_eq=0, run_hit=0, match_cnt=0, mismatch_cnt=0, run counter 0.
REQ-031 Reset mid-transfer SHALL discard any held result; after deassertion in_ready=1 and no stale out_valid.

Structure
REQ-032 A shared package match_pkg SHALL hold the FSM state enum (EMPTY, FULL) and default parameter constants.
REQ-033 The combinational W-bit equality SHALL live in one sub-module pair_eq (inputs a, b; output eq), instantiated once.

Verification
REQ-034 Reset, then pairs (3,2),(2,3),(2,2),(1,3) with out_ready=1 -> out_eq 0,0,1,0 one cycle after each accept; match_cnt=1, mismatch_cnt=3.
REQ-035 Four consecutive (1,1), RUN_LEN=3 -> run_hit=1 on the third result only; run counter 1 after the fourth.
REQ-036 out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, result held stable, counters unchanged until consume.
REQ-037 CNT_W=2, five matches -> match_cnt sticks at 3.
REQ-038 clear on the same cycle as an accepted (2,2) after counts 4/4 -> match_cnt=1, mismatch_cnt=0, out_valid unaffected.
REQ-039 rst_n low while out_valid=1 -> out_valid=0 and all outputs 0 with no clock edge required.
